memory_arbiter: RTL and testbench

Arbitrates the pipeline's instruction-fetch and data-access requests onto the single-ported RAM and returns the `ihit` and `dhit` pulses consumed by the hazard unit and the pipeline latches. It sits between the datapath (request unit and fetch logic) and the RAM model. It holds a one-request-at-a-time grant state machine with fixed data priority and an access watchdog. It also keeps stall-cycle performance counters.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/access_watchdog.sv | 46 ++++
 rtl/memory_arbiter.sv | 166 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types and constants shared by the pipeline memory blocks.
//   word_t          - 32-bit machine word
//   arb_state_t     - grant state of memory_arbiter
//   TIMEOUT_DEFAULT - default watchdog limit, in granted cycles
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/access_watchdog.sv
// access_watchdog: counts the cycles of one granted RAM access and flags an
// access that has waited too long for the RAM.
//   CLK, nRST - clock, asynchronous active-low reset
//   start     - a grant begins next cycle; clears the count
//   active    - a live granted cycle; advances the count
//   ready     - RAM completes this cycle; suppresses expiry
//   expired   - TIMEOUT-th granted cycle passed with no ready (combinational)
module access_watchdog
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic nRST,
  input  logic start,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The first granted cycle sees a count of 0, so TIMEOUT-1 marks the
  // TIMEOUT-th granted cycle.
  assign expired = active && !ready && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: grants instruction-fetch and data requests, one at a time,
// onto a single-ported RAM; data wins simultaneous requests.
//   CLK, nRST                     - clock, asynchronous active-low reset
//   iREN, iaddr                   - fetch request / address
//   dREN, dWEN, daddr, dstore     - data load/store request, address, data
//   ramready, ramload             - RAM completion and read data
//   ihit, iload / dhit, dload     - completion pulses and returned data
//   ramREN, ramWEN, ramaddr, ramstore - RAM strobes, address, write data
//   err                           - pulse on timeout or dREN&dWEN request
//   istall_cnt, dstall_cnt        - free-running stall-cycle counters
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             iREN,
  input  logic [31:0]      iaddr,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  input  logic             ramready,
  input  logic [31:0]      ramload,
  output logic             ihit,
  output logic             dhit,
  output logic [31:0]      iload,
  output logic [31:0]      dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  output logic             err,
  output logic [CNT_W-1:0] istall_cnt,
  output logic [CNT_W-1:0] dstall_cnt
);

  arb_state_t       state_q, state_d;
  logic             first_q;
  logic [CNT_W-1:0] istall_cnt_q, istall_cnt_d;
  logic [CNT_W-1:0] dstall_cnt_q, dstall_cnt_d;

  logic d_req;
  logic wd_start;
  logic wd_active;
  logic wd_expired;
  logic illegal_err;

  assign d_req = dREN | dWEN;

  // A grant always starts from IDLE, so any request seen there opens one.
  assign wd_start  = (state_q == IDLE) && (d_req || iREN);
  // Only cycles where the granted requester still asks count; a dropped
  // request aborts silently rather than running into the watchdog.
  assign wd_active = ((state_q == DGRANT) && d_req) ||
                     ((state_q == IGRANT) && iREN);

  access_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK    (CLK),
    .nRST   (nRST),
    .start  (wd_start),
    .active (wd_active),
    .ready  (ramready),
    .expired(wd_expired)
  );

  // Load and store together is flagged once, on the first data-grant cycle;
  // the store still goes ahead.
  assign illegal_err = (state_q == DGRANT) && first_q && dREN && dWEN;

  // State register and per-access bookkeeping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      first_q      <= 1'b0;
      istall_cnt_q <= '0;
      dstall_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      first_q      <= wd_start;
      istall_cnt_q <= istall_cnt_d;
      dstall_cnt_q <= dstall_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (!d_req || ramready || wd_expired) begin
          state_d = IDLE;
        end
      end
      IGRANT: begin
        if (!iREN || ramready || wd_expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; everything is zero outside a grant.
  always_comb begin
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    err      = 1'b0;
    unique case (state_q)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        err      = wd_expired | illegal_err;
        if (d_req && ramready) begin
          dhit  = 1'b1;
          dload = ramload;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        err     = wd_expired;
        if (iREN && ramready) begin
          ihit  = 1'b1;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

  // Stall counters wrap naturally at 2^CNT_W.
  always_comb begin
    istall_cnt_d = istall_cnt_q;
    dstall_cnt_d = dstall_cnt_q;
    if (iREN && !ihit) begin
      istall_cnt_d = istall_cnt_q + 1'b1;
    end
    if (d_req && !dhit) begin
      dstall_cnt_d = dstall_cnt_q + 1'b1;
    end
  end

  assign istall_cnt = istall_cnt_q;
  assign dstall_cnt = dstall_cnt_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized checks of memory_arbiter against
// a transaction-level expectation built from the access rules.
module tb_memory_arbiter;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [31:0] istall_cnt, dstall_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_istall = 0;
  logic [31:0] exp_dstall = 0;

  always #5 CLK = ~CLK;

  memory_arbiter #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramready(ramready), .ramload(ramload),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .err(err), .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic ire, dre, dwe, rdy, input logic [31:0] ia, da, ds, ld);
    @(posedge CLK);
    #1;
    iREN = ire; dREN = dre; dWEN = dwe; ramready = rdy;
    iaddr = ia; daddr = da; dstore = ds; ramload = ld;
  endtask

  // Outputs sampled on the falling edge; stall model advances afterwards.
  task automatic expect_cycle(input string tag, input logic e_ihit, e_dhit, e_ren, e_wen,
                              input logic [31:0] e_addr, e_store, e_iload, e_dload,
                              input logic e_err);
    @(negedge CLK);
    chk({tag, ".ihit"},     32'(ihit),   32'(e_ihit));
    chk({tag, ".dhit"},     32'(dhit),   32'(e_dhit));
    chk({tag, ".ramREN"},   32'(ramREN), 32'(e_ren));
    chk({tag, ".ramWEN"},   32'(ramWEN), 32'(e_wen));
    chk({tag, ".ramaddr"},  ramaddr,     e_addr);
    chk({tag, ".ramstore"}, ramstore,    e_store);
    chk({tag, ".iload"},    iload,       e_iload);
    chk({tag, ".dload"},    dload,       e_dload);
    chk({tag, ".err"},      32'(err),    32'(e_err));
    chk({tag, ".istall"},   istall_cnt,  exp_istall);
    chk({tag, ".dstall"},   dstall_cnt,  exp_dstall);
    if (iREN && !e_ihit) exp_istall++;
    if ((dREN || dWEN) && !e_dhit) exp_dstall++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ihit"},     32'(ihit),   0);
    chk({tag, ".dhit"},     32'(dhit),   0);
    chk({tag, ".ramREN"},   32'(ramREN), 0);
    chk({tag, ".ramWEN"},   32'(ramWEN), 0);
    chk({tag, ".ramaddr"},  ramaddr,     0);
    chk({tag, ".ramstore"}, ramstore,    0);
    chk({tag, ".iload"},    iload,       0);
    chk({tag, ".dload"},    dload,       0);
    chk({tag, ".err"},      32'(err),    0);
    chk({tag, ".istall"},   istall_cnt,  0);
    chk({tag, ".dstall"},   dstall_cnt,  0);
  endtask

  // One access by a single requester. w = granted cycle index where the RAM
  // answers (>= TO means never); drop_at = granted cycle where the request is
  // withdrawn (-1 for never).
  task automatic access(input string tag, input bit dside, st, ill, input int w, drop_at,
                        input logic [31:0] addr, data, ld);
    logic        ire, dre, dwe, e_ren, e_wen, rdy;
    logic [31:0] ia, da, e_store;
    string       outcome;
    ire     = !dside;
    dre     = dside && (!st || ill);
    dwe     = dside && (st || ill);
    e_ren   = !dside || (dre && !dwe);
    e_wen   = dwe;
    e_store = dside ? data : 32'h0;
    ia      = dside ? ~addr : addr;
    da      = dside ? addr : ~addr;
    outcome = "timeout";
    // Request first seen in IDLE; a stray ramready here is ignored.
    drive(ire, dre, dwe, 1'($urandom_range(0, 1)), ia, da, data, $urandom);
    expect_cycle({tag, ".req"}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g <= TO; g++) begin
      if (g == drop_at) begin
        drive(0, 0, 0, 0, ia, da, data, ld);
        expect_cycle({tag, ".drop"}, 0, 0, !dside, 0, addr, e_store, 0, 0, 0);
        outcome = "abort";
        break;
      end
      rdy = (g == w);
      drive(ire, dre, dwe, rdy, ia, da, data, ld);
      expect_cycle({tag, ".grant"}, !dside && rdy, dside && rdy, e_ren, e_wen, addr, e_store,
                   (!dside && rdy) ? ld : 32'h0, (dside && rdy) ? ld : 32'h0,
                   (!rdy && g == TO - 1) || (ill && g == 0));
      if (rdy) outcome = "hit";
      if (rdy || g == TO - 1) break;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_cycle({tag, ".idle"}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("txn %s side=%s addr=%h w=%0d drop=%0d -> %s", tag, dside ? "D" : "I", addr, w,
             drop_at, outcome);
  endtask

  initial begin
    int          k;
    logic [31:0] a;
    nRST = 1'b0;
    iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    #12;
    check_zero("reset");
    nRST = 1'b1;

    // Single fetch: ready two cycles after grant, three stall cycles.
    access("fetch", 0, 0, 0, 2, -1, 32'h40, 32'h0, 32'h8C010004);
    chk("fetch.istall_total", istall_cnt, 32'd3);

    // Simultaneous data and fetch requests: data served first.
    drive(1, 1, 0, 0, 32'h44, 32'h100, 0, 32'h11111111);
    expect_cycle("both.req", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 32'h44, 32'h100, 0, 32'h11111111);
    expect_cycle("both.dwait", 0, 0, 1, 0, 32'h100, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 32'h44, 32'h100, 0, 32'hA5A5A5A5);
    expect_cycle("both.dhit", 0, 1, 1, 0, 32'h100, 0, 0, 32'hA5A5A5A5, 0);
    drive(1, 0, 0, 1, 32'h44, 32'h100, 0, 32'h22222222);
    expect_cycle("both.gap", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 32'h44, 32'h100, 0, 32'h5A5A5A5A);
    expect_cycle("both.ihit", 1, 0, 1, 0, 32'h44, 0, 32'h5A5A5A5A, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_cycle("both.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("txn both data=0x100 fetch=0x44 -> dhit then ihit");

    access("store", 1, 1, 0, 2, -1, 32'h200, 32'hDEADBEEF, 32'h0);
    access("flush", 0, 0, 0, TO + 1, 1, 32'h48, 32'h0, 32'h12345678);
    access("timeout_i", 0, 0, 0, TO + 1, -1, 32'h4C, 32'h0, 32'h0);
    access("timeout_d", 1, 0, 0, TO + 1, -1, 32'h204, 32'h0, 32'h0);
    access("edge_ready", 1, 0, 0, TO - 1, -1, 32'h208, 32'h0, 32'hCAFEF00D);
    access("illegal", 1, 0, 1, 1, -1, 32'h20C, 32'h0BADF00D, 32'h0);

    // Asynchronous reset in the middle of a data grant.
    drive(0, 1, 0, 0, 0, 32'h300, 0, 0);
    expect_cycle("rst.req", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 32'h300, 0, 0);
    expect_cycle("rst.grant", 0, 0, 1, 0, 32'h300, 0, 0, 0, 0);
    #2 nRST = 1'b0;
    #1 check_zero("rst.async");
    exp_istall = 0;
    exp_dstall = 0;
    dREN = 0;
    @(negedge CLK);
    nRST = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFF);
    expect_cycle("rst.after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("txn reset_mid_dgrant -> dropped");

    // Randomized accesses.
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 4));
      a = $urandom & 32'hFFFFFFFC;
      case (k)
        0: access("rnd_fetch", 0, 0, 0, int'($urandom_range(0, TO - 1)), -1, a, 0, $urandom);
        1: access("rnd_load", 1, 0, 0, int'($urandom_range(0, TO - 1)), -1, a, $urandom, $urandom);
        2: access("rnd_store", 1, 1, 0, int'($urandom_range(0, TO - 1)), -1, a, $urandom, $urandom);
        3: access("rnd_timeout", 1'($urandom_range(0, 1)), 0, 0, TO + 1, -1, a, $urandom, $urandom);
        default: access("rnd_abort", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, TO + 1,
                        int'($urandom_range(0, TO - 2)), a, $urandom, $urandom);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
